syn_fifo: RTL and testbench
===========================

SYN_FIFO -- requirements
Module: syn_fifo

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Parameter DATA_WIDTH, default 8: width of each stored word.
REQ-003 Parameter DEPTH, default 8: number of storage entries; power of two, >= 2.
REQ-004 Parameter ADDR_WIDTH, default 3: pointer width; equals log2(DEPTH).
REQ-005 clk  input  1: rising-edge clock for all sequential logic.
REQ-006 rst_n  input  1: asynchronous reset, asserted when 1 (active-high despite the name).
REQ-007 wr_en_i  input  1: write request, sampled on rising clk.
REQ-008 data_i  input  DATA_WIDTH: write data, captured with an accepted write.
REQ-009 full_o  output  1: high when DEPTH entries are stored.
REQ-010 rd_en_i  input  1: read request, sampled on rising clk.
REQ-011 data_o  output  DATA_WIDTH: registered read data.
REQ-012 empty_o  output  1: high when zero entries are stored.

Function
REQ-013 Write accept: wr_en_i=1 and full_o=0 at a rising edge SHALL store data_i at the write pointer and advance the write pointer by one.
REQ-014 Read accept: rd_en_i=1 and empty_o=0 at a rising edge SHALL load data_o with the word at the read pointer and advance the read pointer by one.
REQ-015 Read latency: data_o SHALL be valid after the rising edge that accepts the read (one-cycle latency, in strict FIFO order).
REQ-016 data_o SHALL hold its last value when no read is accepted.
REQ-017 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-018 Occupancy tracking SHALL use an ADDR_WIDTH+1-bit count (0..DEPTH), or equivalent extra-bit pointers.
REQ-019 full_o and empty_o SHALL be derived combinationally from registered state only, with no combinational path from the enable inputs.
REQ-020 Overflow: a write while full_o=1 SHALL be ignored, leaving memory, pointers and count unchanged.
REQ-021 Underflow: a read while empty_o=1 SHALL be ignored, leaving pointers and count unchanged and holding data_o.
REQ-022 Simultaneous write and read, not full and not empty: both SHALL be accepted and the count SHALL stay unchanged.
REQ-023 Simultaneous write and read when empty: only the write SHALL be accepted.
REQ-024 Simultaneous write and read when full: only the read SHALL be accepted.
REQ-025 Memory contents SHALL not require a reset; stale entries SHALL never be observable through data_o.

Reset
REQ-026 rst_n=1 SHALL immediately, without waiting for clk, clear both pointers and the count, and set data_o=0, empty_o=1 and full_o=0.
REQ-027 A reset asserted mid-operation SHALL discard all stored entries.
REQ-028 After rst_n is released, the first rising edge SHALL accept operations normally.

Structure
REQ-029 DATA_WIDTH, DEPTH and ADDR_WIDTH defaults SHALL live in a shared package syn_fifo_pkg.
REQ-030 Storage SHALL be a sub-module fifo_mem: a simple dual-port register array with one synchronous write port and one registered read port.
REQ-031 Pointer, count and flag logic SHALL reside in syn_fifo.

Verification (clk period 10 ns)
REQ-032 Reset sequence: hold rst_n=1 for 10 ns -> empty_o=1, full_o=0, data_o=0 before any clock edge.
REQ-033 Fill: write data 0..7 on 8 consecutive cycles -> empty_o falls after the first write and full_o=1 after the eighth write.
REQ-034 Drain: rd_en_i=1 for 8 cycles -> data_o reads 0,1,...,7 one cycle after each accepted read, then empty_o=1 and full_o=0.
REQ-035 Overflow/underflow: a 9th write of 8'hAA while full is dropped (later reads never show 8'hAA); a read while empty holds data_o at 7.
REQ-036 Wrap plus simultaneous access: write 5 words, read 3, then do 6 simultaneous write/read cycles -> the count stays at 2 and output order is preserved across the pointer wrap.
REQ-037 Reset mid-operation: store 4 words, then pulse rst_n=1 -> empty_o=1 and data_o=0 immediately, and a following read returns nothing new.

Source files
------------

// File: rtl/syn_fifo_pkg.sv
// ---------------------------------------------------------------------------
// syn_fifo_pkg
//   Shared defaults and small types for the synchronous FIFO slice.
//   DATA_WIDTH_DEF : default stored word width
//   DEPTH_DEF      : default number of entries (power of two, >= 2)
//   ADDR_WIDTH_DEF : default pointer width, log2(DEPTH_DEF)
// ---------------------------------------------------------------------------
package syn_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 8;
  localparam int ADDR_WIDTH_DEF = 3;

  // Occupancy flags travel together; both come from the registered count.
  typedef struct packed {
    logic empty;
    logic full;
  } fifo_flags_t;

  // True when v is a power of two and at least 2.
  function automatic logic is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem
//   Simple dual-port register array: one synchronous write port and one
//   registered read port. The array itself is not reset; only the read
//   register is, so the FIFO output powers up / resets to zero.
//
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset of the read register
//   wr_en    : write strobe (already qualified against full)
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read strobe (already qualified against empty)
//   rd_addr  : read address
//   rd_data  : registered read data, held when rd_en is low
// ---------------------------------------------------------------------------
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage has no reset: a slot is only ever read after it was written,
  // so stale contents cannot reach rd_data.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/syn_fifo.sv
// ---------------------------------------------------------------------------
// syn_fifo
//   Single-clock FIFO with registered read data (one-cycle read latency).
//   Pointers, occupancy count and flags live here; storage is fifo_mem.
//
//   clk      : rising-edge clock
//   rst_n    : asynchronous reset, ACTIVE HIGH despite the name
//   wr_en_i  : write request; accepted when not full
//   data_i   : write data
//   full_o   : DEPTH entries stored
//   rd_en_i  : read request; accepted when not empty
//   data_o   : read data, valid after the edge that accepts the read,
//              held otherwise
//   empty_o  : no entries stored
// ---------------------------------------------------------------------------
module syn_fifo
  import syn_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  full_o,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o
);

  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  fifo_flags_t           flags;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags depend only on the registered count, never on the enables.
  assign flags.empty = (count == '0);
  assign flags.full  = (count == CNT_FULL);
  assign empty_o     = flags.empty;
  assign full_o      = flags.full;

  // Gating with the flags covers every corner: a write while full and a
  // read while empty are dropped, so write+read when empty takes only the
  // write and write+read when full takes only the read.
  assign wr_acc = wr_en_i & ~flags.full;
  assign rd_acc = rd_en_i & ~flags.empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;   // idle, or write+read cancels out
      endcase
    end
  end

  // wr_ptr and rd_ptr only coincide when empty (no read accepted) or full
  // (no write accepted), so the ports never collide on one address.
  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst_n),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (data_i),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (data_o)
  );

endmodule

// File: tb/tb_syn_fifo.sv
// ---------------------------------------------------------------------------
// tb_syn_fifo
//   Directed scenarios followed by random traffic. A queue models the FIFO
//   contents; every accepted read pushes its expected word into a
//   scoreboard, and an independent monitor pops and compares data_o one
//   cycle after the DUT accepts a read (and checks data_o holds otherwise).
// ---------------------------------------------------------------------------
module tb_syn_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en_i;
  logic [DW-1:0] data_i;
  logic          full_o;
  logic          rd_en_i;
  logic [DW-1:0] data_o;
  logic          empty_o;

  syn_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en_i (wr_en_i),
    .data_i  (data_i),
    .full_o  (full_o),
    .rd_en_i (rd_en_i),
    .data_o  (data_o),
    .empty_o (empty_o)
  );

  initial forever #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [DW-1:0] mdl[$];    // model FIFO contents
  logic [DW-1:0] exp_q[$];  // scoreboard of expected read words
  logic [DW-1:0] mon_last = '0;
  logic          mon_pending = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: a read is accepted at a posedge when rd_en_i=1 and empty_o=0
  // just before it; the word appears on data_o after that edge.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (mon_pending) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_read: got %0h expected no read at %0t", data_o, $time);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", data_o, e);
          mon_last = e;
        end
      end else begin
        chk("hold", data_o, mon_last);
      end
      mon_pending = !rst_n && rd_en_i && !empty_o;
    end
  end

  // One cycle of stimulus; called at posedge+1, returns at next posedge+1.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    logic rd_ok, wr_ok;
    wr_en_i = w;
    rd_en_i = r;
    data_i  = d;
    rd_ok = r && (mdl.size() > 0);
    wr_ok = w && (mdl.size() < DEPTH);
    if (rd_ok) exp_q.push_back(mdl.pop_front());
    if (wr_ok) mdl.push_back(d);
    @(posedge clk);
    #1;
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    chk("empty", empty_o, mdl.size() == 0);
    chk("full",  full_o,  mdl.size() == DEPTH);
  endtask

  // Async reset pulse between edges; checks outputs before any clock edge.
  task automatic pulse_reset();
    #2;
    rst_n = 1'b1;
    #1;
    chk("rst_empty", empty_o, 1'b1);
    chk("rst_full",  full_o,  1'b0);
    chk("rst_data",  data_o,  '0);
    mdl.delete();
    exp_q.delete();
    mon_pending = 1'b0;
    mon_last    = '0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bias;
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    data_i  = '0;
    rst_n   = 1'b1;
    #2;
    chk("init_empty", empty_o, 1'b1);
    chk("init_full",  full_o,  1'b0);
    chk("init_data",  data_o,  '0);
    #8;
    rst_n = 1'b0;
    @(posedge clk);
    #1;

    // Fill 0..7, then an overflow write of AA that must be dropped.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(i));
    step(1'b1, 1'b0, 8'hAA);
    // Drain in order, then underflow reads that must hold data_o at 7.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    chk("underflow_hold", data_o, 8'h07);

    // Write 5, read 3, then 6 simultaneous cycles across the wrap.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(8'h20 + i));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, DW'(8'h30 + i));
      chk("simul_count", mdl.size(), 2);
    end
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);

    // Simultaneous when empty (write only) and when full (read only).
    step(1'b1, 1'b1, 8'h41);
    chk("wr_rd_empty_count", mdl.size(), 1);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 1'b0, DW'(8'h50 + i));
    step(1'b1, 1'b1, 8'hBB);
    chk("wr_rd_full_count", mdl.size(), DEPTH - 1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0);

    // Store 4 then reset mid-operation; a later read yields nothing new.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'(8'h60 + i));
    pulse_reset();
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);
    chk("post_rst_data", data_o, '0);

    // Random traffic, alternating write-heavy and read-heavy phases.
    for (int p = 0; p < 4; p++) begin
      bias = (p % 2 == 0) ? 75 : 30;
      for (int i = 0; i < 100; i++)
        step($urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias - 20,
             DW'($urandom));
    end
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
